des_pipe_sched: RTL
===================

Name: des_pipe_sched

Overview:
- Issue scheduler and controller for the 16-stage pipelined DES core. It shares one core between two requesters, each with its own encrypt/decrypt mode, and drives the core's data input and mode flag.
- The core's round keys are held in one register bank shared by all stages, so flag changes are fenced: the pipeline drains before the mode switches.
- Tracks in-flight blocks with a valid/tag shift register and returns each result tagged with its requester.

Parameters:
- DES_LAT, 16, core latency in cycles from issue to result valid on the core output.
- MAX_BURST, 32, maximum consecutive same-mode issues while an other-mode request waits (anti-starvation).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a block.
- req0_ready  out  1  requester 0 block accepted this cycle.
- req0_mode  in  1  1 = encrypt, 0 = decrypt.
- req0_data  in  64  plaintext or ciphertext block.
- req1_valid, req1_ready, req1_mode, req1_data: same as requester 0, for requester 1.
- core_flag  out  1  mode flag to the core (1 = encrypt).
- core_din  out  64  block to the core.
- core_dout  in  64  core result.
- resp_valid  out  1  result valid; no backpressure.
- resp_id  out  1  requester of the result.
- resp_mode  out  1  mode the block was processed in.
- resp_data  out  64  result, equal to core_dout.
- idle  out  1  pipeline empty and nothing issuing; external key reload is permitted only while idle=1.

Behaviour:
- Reset values: state=RUN, cur_mode=1, core_flag=1, valid/tag shift register cleared, burst_cnt=0, RR pointer=0. All ready and resp outputs are 0; idle=1.
- Reset mid-operation: in-flight blocks are discarded and no resp_valid is produced for them. The core has no reset, so its stale output is ignored.
- core_flag = cur_mode register.
- Issue: at most one block per cycle. The handshake completes when valid && ready in the same cycle. core_din = the granted data in that same cycle; otherwise core_din = 0.
- Tracking: v[1..DES_LAT] shift register carrying {id, mode}. A block issued in cycle i sets v[k] in cycle i+k.
- Result: resp_valid = v[DES_LAT], with resp_id and resp_mode from that tag and resp_data = core_dout. A block issued in cycle i is returned in cycle i+16.
- State RUN:
  - Eligible requesters are those with valid && mode==cur_mode.
  - The 2-way round-robin arbiter grants one eligible requester. The pointer advances past the grantee only when a grant occurs.
  - burst_cnt increments on each issue while an other-mode request is pending, and clears otherwise.
  - Switch condition: an other-mode request is pending AND (no eligible requester OR burst_cnt==MAX_BURST).
  - When the switch condition holds: no issue that cycle, all ready=0, go to DRAIN.
- State DRAIN:
  - No issue; all ready=0.
  - When v[1..13] are all zero, cur_mode toggles at the end of that cycle and the state goes to SWITCH.
  - This guarantees the last old-mode block finishes stage 16 under the old keys.
- State SWITCH:
  - Exactly one cycle, no issue, while the core latches the keys for the new flag. Then go to RUN and clear burst_cnt.
- Timing guarantee: the last old-mode issue in cycle i gives the first new-mode issue no earlier than cycle i+16 (15 idle cycles).
- Simultaneous events:
  - Both requesters valid with different modes: only the one matching cur_mode is eligible.
  - Both requesters with the same mode: strict alternation.
- A requester's mode must stay constant while its valid is high and unaccepted.
- idle = RUN && no issue this cycle && v[1..16] all zero.

Decomposition:
- Package des_pkg holds:
  - DES_LAT=16.
  - MODE_ENC=1'b1 and MODE_DEC=1'b0.
  - State encoding {RUN, DRAIN, SWITCH}.
  - Tag type {id, mode}.
- Sub-module des_rr_arb: 2-way round-robin arbiter with a req vector, a grant vector, and an advance-on-grant pointer.

Test Plan:
- Single encrypt: req0 with mode=1, data 0123456789ABCDEF, and core keys from key 133457799BBCDFF1. Required: resp_valid exactly 16 cycles after the handshake, resp_data 85E813540F0AB405, resp_id=0.
- Back-to-back: 20 encrypt blocks alternated from req0 and req1. Required: one issue per cycle, results in issue order 16 cycles later, ids alternating 0,1,0,1.
- Mode switch:
  - Drive req0 encrypt, then req1 decrypt of 85E813540F0AB405.
  - core_flag must fall in cycle i+15 and the next issue occur in cycle i+16.
  - req1 response must be 0123456789ABCDEF and the req0 result must be correct.
- Starvation: req0 streams encrypt continuously while req1 holds a decrypt request. Required: after 32 issues, DRAIN is entered and req1 is served.
- Async reset mid-flight: assert rst with 5 blocks in flight. Required: outputs reset immediately, no resp_valid for those blocks, idle=1 after release.
- idle: after the last response, idle=1. Any issue pulls idle low that same cycle.

Source files
------------

// File: rtl/des_pkg.sv
// Shared definitions for the DES pipeline issue scheduler.
//   DES_LAT  : core latency from issue to result on the core output
//   MODE_ENC : core flag value for encryption
//   MODE_DEC : core flag value for decryption
//   state_t  : scheduler state (run / drain / switch)
//   tag_t    : per-block tracking tag {requester id, mode}
package des_pkg;

  localparam int unsigned DES_LAT = 16;

  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SWITCH
  } state_t;

  typedef struct packed {
    logic id;
    logic mode;
  } tag_t;

endpackage

// File: rtl/des_rr_arb.sv
// Two-way round-robin arbiter.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   req   : request vector, bit n = requester n
//   grant : one-hot grant (or zero when nothing is requested)
// The pointer names the requester with priority; it moves past the
// grantee only in cycles where a grant is actually given.
module des_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    if (ptr == 1'b0) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      // grantee 0 hands priority to 1 and vice versa
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/des_pipe_sched.sv
// Issue scheduler for a 16-stage pipelined DES core shared by two
// requesters. Mode changes are fenced: the pipeline drains, the flag
// toggles, and one cycle is left for the core to reload round keys.
//   clk, rst                 : clock, asynchronous active-low reset
//   reqN_valid/ready/mode/data : requester N handshake (mode 1 = encrypt)
//   core_flag, core_din      : mode flag and data block to the core
//   core_dout                : core result
//   resp_valid/id/mode/data  : tagged result, no backpressure
//   idle                     : pipeline empty and nothing issuing
module des_pipe_sched #(
  parameter int unsigned DES_LAT   = des_pkg::DES_LAT,
  parameter int unsigned MAX_BURST = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic [63:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic [63:0] req1_data,
  output logic        core_flag,
  output logic [63:0] core_din,
  input  logic [63:0] core_dout,
  output logic        resp_valid,
  output logic        resp_id,
  output logic        resp_mode,
  output logic [63:0] resp_data,
  output logic        idle
);

  import des_pkg::*;

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  // Stages that must be empty before the flag may toggle.
  localparam int unsigned FENCE = DES_LAT - 3;

  state_t              state;
  logic                cur_mode;
  logic [BW-1:0]       burst_cnt;
  logic [DES_LAT:1]    v;
  tag_t [DES_LAT:1]    tags;

  logic [1:0]          elig;
  logic [1:0]          arb_req;
  logic [1:0]          grant;
  logic                other;
  logic                sw_cond;
  logic                issue;
  logic                fence_clear;

  always_comb begin
    elig[0] = req0_valid && (req0_mode == cur_mode);
    elig[1] = req1_valid && (req1_mode == cur_mode);
    other   = (req0_valid && (req0_mode != cur_mode)) ||
              (req1_valid && (req1_mode != cur_mode));
    sw_cond = other && ((elig == 2'b00) || (burst_cnt == BW'(MAX_BURST)));
    // Only RUN issues, and never in the cycle that decides to switch.
    arb_req = (rst && (state == ST_RUN) && !sw_cond) ? elig : 2'b00;
  end

  des_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .grant (grant)
  );

  always_comb begin
    issue       = |grant;
    req0_ready  = grant[0];
    req1_ready  = grant[1];
    core_din    = '0;
    if (grant[0])      core_din = req0_data;
    else if (grant[1]) core_din = req1_data;
    core_flag   = cur_mode;
    fence_clear = ~|v[FENCE:1];
    resp_valid  = v[DES_LAT];
    resp_id     = v[DES_LAT] & tags[DES_LAT].id;
    resp_mode   = v[DES_LAT] & tags[DES_LAT].mode;
    resp_data   = v[DES_LAT] ? core_dout : '0;
    idle        = (state == ST_RUN) && !issue && ~|v;
  end

  // Valid/tag shift register mirrors the core pipeline position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v    <= '0;
      tags <= '0;
    end else begin
      v[1]         <= issue;
      tags[1].id   <= grant[1];
      tags[1].mode <= cur_mode;
      for (int unsigned k = 2; k <= DES_LAT; k++) begin
        v[k]    <= v[k-1];
        tags[k] <= tags[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      cur_mode  <= MODE_ENC;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          burst_cnt <= (issue && other) ? burst_cnt + 1'b1 : '0;
          if (sw_cond) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fence_clear) begin
            cur_mode <= ~cur_mode;
            state    <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          burst_cnt <= '0;
          state     <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
